mem_port_arbiter: RTL and testbench

//  Shares the single 512-bit password-store RAM port between N_REQ requesters: command path (req 0), flash-mirror engine (req 1).

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the password-store RAM port arbiter.
// Holds the arbiter FSM states, the read-return tag and the round-robin pointer helper.
package mem_arb_pkg;

  localparam int DEF_N_REQ  = 2;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 512;
  localparam int DEF_RD_LAT = 2;

  // Requester id width covers the full 2..4 requester range.
  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    ZERO_RUN = 2'd1,
    ZERO_DRN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above ptr_i,
// wrapping past the top requester. Grant is one-hot or zero.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic found;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_i[i] && (i == (int'(ptr_i) + k) % N_REQ)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one password-store RAM port between N_REQ requesters with round-robin grant,
// in-order read return and a whole-store zeroize sequencer. Define MEM_ARB_LOCK_EN for locked RMW grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  input  logic                     zeroize_req,
  output logic                     zeroize_done,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_dout,
  input  logic [DATA_W-1:0]        mem_din
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_dout_q, mem_dout_d;
  logic [ID_W-1:0]     mem_id_q, mem_id_d;
  rd_tag_t             pipe_q [RD_LAT];
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                zeroize_done_q, zeroize_done_d;

  logic [N_REQ-1:0]    elig;
  logic [N_REQ-1:0]    gnt;
  logic                zero_start;
  logic                arb_en;
  logic                accept;
  logic [ID_W-1:0]     gnt_id;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                tags_busy;
  rd_tag_t             exit_tag;

`ifdef MEM_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                zero_pend_q, zero_pend_d;
  logic                sel_lock;

  // While locked only the owner is eligible; a zeroize request waits for the release.
  always_comb begin
    elig = req_valid;
    if (lock_q) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i != int'(owner_q)) elig[i] = 1'b0;
      end
    end
  end

  assign zero_start = (state_q == ARB) && (zeroize_req || zero_pend_q) && !lock_q;

  always_comb begin
    lock_d      = lock_q;
    owner_d     = owner_q;
    zero_pend_d = zero_pend_q;
    if (accept) begin
      lock_d  = sel_lock;
      owner_d = gnt_id;
    end
    if (zero_start) begin
      zero_pend_d = 1'b0;
    end else if ((state_q == ARB) && zeroize_req && lock_q) begin
      zero_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      owner_q     <= '0;
      zero_pend_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      zero_pend_q <= zero_pend_d;
    end
  end
`else
  logic lock_unused;

  assign lock_unused = ^req_lock;
  assign elig        = req_valid;
  assign zero_start  = (state_q == ARB) && zeroize_req;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  // Zeroize wins over any request in its start cycle and blocks grants until it completes.
  assign arb_en    = (state_q == ARB) && !zero_start;
  assign req_ready = arb_en ? gnt : '0;
  assign accept    = |req_ready;

  always_comb begin
    gnt_id    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    sel_lock  = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id    = ID_W'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
`ifdef MEM_ARB_LOCK_EN
        sel_lock  = req_lock[i];
`endif
      end
    end
  end

  always_comb begin
    tags_busy = mem_en_q && !mem_we_q;
    for (int k = 0; k < RD_LAT; k++) begin
      tags_busy = tags_busy || pipe_q[k].vld;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_ptr_d       = rr_ptr_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_dout_d     = mem_dout_q;
    mem_id_d       = mem_id_q;
    zeroize_done_d = 1'b0;
    case (state_q)
      ARB: begin
        if (zero_start) begin
          state_d = ZERO_RUN;
          cnt_d   = '0;
        end else if (accept) begin
          mem_en_d   = 1'b1;
          mem_we_d   = sel_we;
          mem_addr_d = sel_addr;
          mem_dout_d = sel_wdata;
          mem_id_d   = gnt_id;
          rr_ptr_d   = next_ptr(gnt_id, N_REQ);
        end
      end
      ZERO_RUN: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = cnt_q;
        mem_dout_d = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ZERO_DRN;
      end
      ZERO_DRN: begin
        // Reads issued before the zeroize still return before completion is signalled.
        if (!tags_busy) begin
          zeroize_done_d = 1'b1;
          state_d        = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign exit_tag = pipe_q[RD_LAT-1];

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (exit_tag.vld && (exit_tag.id == ID_W'(i))) rsp_valid_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_dout_q     <= '0;
      mem_id_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      zeroize_done_q <= 1'b0;
      // NOTE: the tag pipe is reset entry by entry; a stale valid tag would fire rsp_valid after reset.
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, as hardware does.
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_dout_q     <= mem_dout_d;
      mem_id_q       <= mem_id_d;
      rsp_valid_q    <= rsp_valid_d;
      zeroize_done_q <= zeroize_done_d;
      if (exit_tag.vld) rsp_rdata_q <= mem_din;
      pipe_q[0] <= rd_tag_t'{vld: mem_en_q && !mem_we_q, id: mem_id_q};
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_dout     = mem_dout_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign zeroize_done = zeroize_done_q;
  assign busy         = (state_q != ARB) || tags_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-latency RAM model; expectations are hand-derived.
// Lock-step expectations follow MEM_ARB_LOCK_EN when the bench is built with it.
module tb_mem_port_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 512;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    zeroize_req;
  logic                    zeroize_done;
  logic                    busy;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_dout;
  logic [DATA_W-1:0]       mem_din;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  mem_port_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .zeroize_req  (zeroize_req),
    .zeroize_done (zeroize_done),
    .busy         (busy),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background contents for never-written words; address 0x005 holds the A5 pattern.
  function automatic logic [DATA_W-1:0] patt(input logic [ADDR_W-1:0] a);
    if (a == 12'h005) return {64{8'hA5}};
    return {32{4'hA, a}};
  endfunction

  bit [DATA_W-1:0]   mem_model [DEPTH];
  bit                wr_flag   [DEPTH];
  logic [DATA_W-1:0] rd_s1, rd_s2;
  int                zw_cnt = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_model[mem_addr] <= mem_dout;
        wr_flag[mem_addr]   <= 1'b1;
      end else begin
        rd_s1 <= wr_flag[mem_addr] ? mem_model[mem_addr] : patt(mem_addr);
      end
    end
    rd_s2 <= rd_s1;
    if (mem_en && mem_we && (mem_dout == '0)) zw_cnt <= zw_cnt + 1;
  end

  assign mem_din = rd_s2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i]                  = v;
    req_we[i]                     = we;
    req_lock[i]                   = lk;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rsp_seen;
    logic rdy_seen;
    logic busy_low;
    logic done_seen;

    rst_n       = 1'b0;
    req_valid   = '0;
    req_we      = '0;
    req_lock    = '0;
    req_addr    = '0;
    req_wdata   = '0;
    zeroize_req = 1'b0;
    repeat (3) tick();

    check("rst_mem_en",   mem_en, 1'b0);
    check("rst_mem_we",   mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_dout", mem_dout, '0);
    check("rst_rsp_vld",  rsp_valid, '0);
    check("rst_rsp_data", rsp_rdata, '0);
    check("rst_zdone",    zeroize_done, 1'b0);
    check("rst_busy",     busy, 1'b0);
    check("rst_ready",    req_ready, '0);
    rst_n = 1'b1;
    tick();

    // Contention: both requesters read for four cycles, grants alternate from requester 0.
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h020, '0);
    #1;
    check("cont_rdy0", req_ready, 2'b01);
    tick();
    check("cont_rdy1", req_ready, 2'b10);
    check("cont_maddr0", mem_addr, 12'h010);
    check("cont_busy", busy, 1'b1);
    tick();
    check("cont_rdy2", req_ready, 2'b01);
    tick();
    check("cont_rdy3", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("cont_rsp0", rsp_valid, 2'b01);
    check("cont_dat0", rsp_rdata, patt(12'h010));
    tick();
    check("cont_rsp1", rsp_valid, 2'b10);
    check("cont_dat1", rsp_rdata, patt(12'h020));
    tick();
    check("cont_rsp2", rsp_valid, 2'b01);
    check("cont_dat2", rsp_rdata, patt(12'h010));
    tick();
    check("cont_rsp3", rsp_valid, 2'b10);
    tick();
    check("cont_rsp_end", rsp_valid, 2'b00);

    // Single read of 0x005: response exactly four cycles after accept.
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h005, '0);
    #1;
    check("sr_rdy", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("sr_mem_en", mem_en, 1'b1);
    check("sr_mem_we", mem_we, 1'b0);
    check("sr_mem_addr", mem_addr, 12'h005);
    tick();
    check("sr_idle_en", mem_en, 1'b0);
    check("sr_idle_addr", mem_addr, 12'h005);
    tick();
    check("sr_rsp_early", rsp_valid, 2'b00);
    tick();
    check("sr_rsp", rsp_valid, 2'b01);
    check("sr_data", rsp_rdata, {64{8'hA5}});
    tick();
    check("sr_rsp_pulse", rsp_valid, 2'b00);
    check("sr_busy_idle", busy, 1'b0);

    // Requester 1 writes 0x123, requester 0 reads it back the next cycle.
    set_req(1, 1'b1, 1'b1, 1'b0, 12'h123, {16{32'hDEADBEEF}});
    #1;
    check("wr_rdy", req_ready, 2'b10);
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h123, '0);
    #1;
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 12'h123);
    check("wr_mem_dout", mem_dout, {16{32'hDEADBEEF}});
    check("rd_rdy", req_ready, 2'b01);
    tick();
    req_valid = '0;
    repeat (3) tick();
    check("wr_rd_rsp", rsp_valid, 2'b01);
    check("wr_rd_data", rsp_rdata, {16{32'hDEADBEEF}});

    // Reset one cycle after a read accept drops the read.
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h020, '0);
    #1;
    check("mr_rdy", req_ready, 2'b10);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("mr_mem_en", mem_en, 1'b0);
    check("mr_mem_addr", mem_addr, '0);
    check("mr_rsp_data", rsp_rdata, '0);
    check("mr_busy", busy, 1'b0);
    tick();
    rst_n    = 1'b1;
    rsp_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      rsp_seen = rsp_seen | (|rsp_valid);
    end
    check("mr_no_rsp", rsp_seen, 1'b0);
    req_valid = 2'b11;
    #1;
    check("mr_ptr_rst", req_ready, 2'b01);
    req_valid = '0;

    // Zeroize: prefill both store ends, then clear with a read held pending throughout.
    set_req(0, 1'b1, 1'b1, 1'b0, 12'h000, {16{32'h1111_0000}});
    tick();
    set_req(0, 1'b1, 1'b1, 1'b0, 12'hFFF, {16{32'h2222_0FFF}});
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h005, '0);
    zeroize_req = 1'b1;
    #1;
    check("z_start_rdy", req_ready, 2'b00);
    tick();
    zeroize_req = 1'b0;
    rdy_seen    = 1'b0;
    busy_low    = 1'b0;
    done_seen   = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (zeroize_done) begin
        done_seen = 1'b1;
        break;
      end
      rdy_seen = rdy_seen | (|req_ready);
      if (!busy) busy_low = 1'b1;
      tick();
    end
    req_valid = '0;
    check("z_done_seen", done_seen, 1'b1);
    check("z_ready_low", rdy_seen, 1'b0);
    check("z_busy_high", busy_low, 1'b0);
    check("z_write_cnt", 32'(zw_cnt), 32'd4096);
    tick();
    check("z_done_pulse", zeroize_done, 1'b0);
    check("z_busy_end", busy, 1'b0);

    set_req(0, 1'b1, 1'b0, 1'b0, 12'h000, '0);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'hFFF, '0);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h005, '0);
    tick();
    req_valid = '0;
    tick();
    check("zr_rsp0", rsp_valid, 2'b01);
    check("zr_dat000", rsp_rdata, '0);
    tick();
    check("zr_rsp1", rsp_valid, 2'b01);
    check("zr_datFFF", rsp_rdata, '0);
    tick();
    check("zr_rsp2", rsp_valid, 2'b01);
    check("zr_dat005", rsp_rdata, '0);

    // Requester 1 reads with lock, then releases with a write while requester 0 waits.
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, '0);
    set_req(1, 1'b1, 1'b0, 1'b1, 12'h020, '0);
    #1;
    check("lk_rdy0", req_ready, 2'b10);
    tick();
    set_req(1, 1'b1, 1'b1, 1'b0, 12'h020, {16{32'h5555_AAAA}});
    #1;
`ifdef MEM_ARB_LOCK_EN
    check("lk_rdy1", req_ready, 2'b10);
    tick();
    check("lk_rdy2", req_ready, 2'b01);
`else
    check("lk_rdy1", req_ready, 2'b01);
    tick();
    check("lk_rdy2", req_ready, 2'b10);
`endif
    req_valid = '0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
